// File: rtl/fencei_sequencer.sv
// fencei_sequencer: holds the pipeline through D-cache write-back and I-cache invalidate for FENCE.I, then pulses completion
//   clk_i, rst_i (async, active-high)
//   fencei_i, sys_jump_i                   : Execute-stage FENCE.I valid and trap/return redirect
//   dc_flush_req_o / dc_flush_done_i       : D-cache write-back-all request level / completion pulse
//   ic_inv_req_o / ic_inv_done_i           : I-cache invalidate-all request level / completion pulse
//   stall_pipe_o                           : freeze PC/Fetch/Decode/Execute (combinational)
//   fencei_done_o, fencei_timeout_o        : completion pulse / cache-ack timeout pulse
module fencei_sequencer #(
    parameter bit          SKIP_DCACHE    = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fencei_i,
    input  logic sys_jump_i,
    output logic dc_flush_req_o,
    input  logic dc_flush_done_i,
    output logic ic_inv_req_o,
    input  logic ic_inv_done_i,
    output logic stall_pipe_o,
    output logic fencei_done_o,
    output logic fencei_timeout_o
);
    localparam bit TO_EN = TIMEOUT_CYCLES > 0;
    localparam int CW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
    typedef enum logic [1:0] {IDLE, DC_FLUSH, IC_INV, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic served, served_nx;
    logic accept, waiting, ack, timeout;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            served <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            served <= served_nx;
        end
    end
    always_comb begin
        accept    = fencei_i & ~served & ~sys_jump_i;
        waiting   = state == DC_FLUSH || state == IC_INV;
        // only the ack belonging to the current wait state counts
        ack       = state == DC_FLUSH ? dc_flush_done_i : state == IC_INV ? ic_inv_done_i : 1'b0;
        timeout   = TO_EN && waiting && cnt == CNT_LAST && !ack;
        state_nx  = state == IDLE     ? (accept ? (SKIP_DCACHE ? IC_INV : DC_FLUSH) : IDLE)
                  : state == DC_FLUSH ? (ack || timeout ? IC_INV : DC_FLUSH)
                  : state == IC_INV   ? (ack || timeout ? DONE : IC_INV)
                  : IDLE;
        cnt_nx    = TO_EN && waiting && state_nx == state ? cnt + 1'b1 : '0;
        // served stays set while the completed FENCE.I is still held in Execute
        served_nx = fencei_i & (served | state == DONE);
    end
    assign dc_flush_req_o   = state == DC_FLUSH;
    assign ic_inv_req_o     = state == IC_INV;
    assign fencei_done_o    = state == DONE;
    assign fencei_timeout_o = timeout;
    // gated by reset so every output reads 0 while reset is held
    assign stall_pipe_o     = ~rst_i & ((state == IDLE & accept) | waiting);
endmodule

// File: tb/tb_fencei_sequencer.sv
// tb_fencei_sequencer: directed checks of fencei_sequencer in default, skip-D-cache and short-timeout configurations
module tb_fencei_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic fencei = 1'b0, jump = 1'b0, dc_ack = 1'b0, ic_ack = 1'b0;
    logic a_dc, a_ic, a_st, a_dn, a_to;
    logic s_dc, s_ic, s_st, s_dn, s_to;
    logic t_dc, t_ic, t_st, t_dn, t_to;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    fencei_sequencer u_a (
        .clk_i(clk), .rst_i(rst), .fencei_i(fencei), .sys_jump_i(jump),
        .dc_flush_req_o(a_dc), .dc_flush_done_i(dc_ack), .ic_inv_req_o(a_ic), .ic_inv_done_i(ic_ack),
        .stall_pipe_o(a_st), .fencei_done_o(a_dn), .fencei_timeout_o(a_to)
    );
    fencei_sequencer #(.SKIP_DCACHE(1'b1)) u_s (
        .clk_i(clk), .rst_i(rst), .fencei_i(fencei), .sys_jump_i(jump),
        .dc_flush_req_o(s_dc), .dc_flush_done_i(dc_ack), .ic_inv_req_o(s_ic), .ic_inv_done_i(ic_ack),
        .stall_pipe_o(s_st), .fencei_done_o(s_dn), .fencei_timeout_o(s_to)
    );
    fencei_sequencer #(.TIMEOUT_CYCLES(4)) u_t (
        .clk_i(clk), .rst_i(rst), .fencei_i(fencei), .sys_jump_i(jump),
        .dc_flush_req_o(t_dc), .dc_flush_done_i(dc_ack), .ic_inv_req_o(t_ic), .ic_inv_done_i(ic_ack),
        .stall_pipe_o(t_st), .fencei_done_o(t_dn), .fencei_timeout_o(t_to)
    );
    task automatic chk(input string tag, input int c, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        fencei = 1'b0; jump = 1'b0; dc_ack = 1'b0; ic_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    initial begin
        #1;
        chk("rst_dc", 0, a_dc, 1'b0);
        chk("rst_ic", 0, a_ic, 1'b0);
        chk("rst_st", 0, a_st, 1'b0);
        chk("rst_dn", 0, a_dn, 1'b0);
        chk("rst_to", 0, a_to, 1'b0);
        do_reset();
        // test 1: D ack at 5, I ack at 8, done at 9
        fencei = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            dc_ack = c == 5;
            ic_ack = c == 8;
            #1;
            chk("t1_st", c, a_st, c <= 8);
            chk("t1_dc", c, a_dc, c >= 1 && c <= 5);
            chk("t1_ic", c, a_ic, c >= 6 && c <= 8);
            chk("t1_dn", c, a_dn, c == 9);
            chk("t1_to", c, a_to, 1'b0);
            tick();
        end
        dc_ack = 1'b0; ic_ack = 1'b0;
        // test 2: held past done -> no re-trigger; gap cycle -> new sequence
        for (int c = 10; c <= 15; c++) begin
            fencei = c != 13;
            #1;
            chk("t2_st", c, a_st, c >= 14);
            chk("t2_dc", c, a_dc, c == 15);
            chk("t2_dn", c, a_dn, 1'b0);
            tick();
        end
        do_reset();
        // test 3: SKIP_DCACHE, I ack 2 cycles after accept
        fencei = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            ic_ack = c == 2;
            #1;
            chk("t3_dc", c, s_dc, 1'b0);
            chk("t3_st", c, s_st, c <= 2);
            chk("t3_ic", c, s_ic, c == 1 || c == 2);
            chk("t3_dn", c, s_dn, c == 3);
            tick();
        end
        do_reset();
        // test 4a: D never acks -> timeout on 4th DC_FLUSH cycle, then I ack
        fencei = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            ic_ack = c == 6;
            #1;
            chk("t4a_dc", c, t_dc, c >= 1 && c <= 4);
            chk("t4a_to", c, t_to, c == 4);
            chk("t4a_ic", c, t_ic, c == 5 || c == 6);
            chk("t4a_dn", c, t_dn, c == 7);
            tick();
        end
        do_reset();
        // test 4b: D ack on the last count wins; I side then times out
        fencei = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            dc_ack = c == 4;
            #1;
            chk("t4b_to", c, t_to, c == 8);
            chk("t4b_ic", c, t_ic, c >= 5 && c <= 8);
            chk("t4b_dn", c, t_dn, c == 9);
            tick();
        end
        do_reset();
        // test 5: jump blocks accept in IDLE, ignored in IC_INV; stray acks ignored
        fencei = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            jump = c <= 2 || c == 5 || c == 6;
            dc_ack = c == 4 || c == 1;
            ic_ack = c == 4 || c == 6;
            #1;
            chk("t5_st", c, a_st, c >= 3 && c <= 6);
            chk("t5_dc", c, a_dc, c == 4);
            chk("t5_ic", c, a_ic, c == 5 || c == 6);
            chk("t5_dn", c, a_dn, c == 7);
            tick();
        end
        do_reset();
        // test 6: async reset mid DC_FLUSH
        fencei = 1'b1;
        tick();
        tick();
        chk("t6_pre_dc", 2, a_dc, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_dc", 2, a_dc, 1'b0);
        chk("t6_st", 2, a_st, 1'b0);
        chk("t6_ic", 2, a_ic, 1'b0);
        chk("t6_dn", 2, a_dn, 1'b0);
        fencei = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t6_idle_st", c, a_st, 1'b0);
            chk("t6_idle_dc", c, a_dc, 1'b0);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
